// File: rtl/lu_pkg.sv
// Shared LU datapath definitions: operand mode encoding and
// the most-negative-value helper used for overflow detection.
package lu_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_ONES = 2'b11;

  // 100...0 for a w-bit two's-complement value, w <= 64
  function automatic logic [63:0] most_neg(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/twos_comp_pipe_seg_inc.sv
// Parallel-prefix (recursive-doubling) incrementer for one
// carry segment: o_sum = i_a + i_cin, o_co = carry out.
module seg_inc #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_co
);

  localparam int L = $clog2(SEG);

  // w_pre[L][i] is the AND of i_a[i:0]
  logic [L:0][SEG-1:0] w_pre;
  logic [SEG-1:0]      w_c;

  assign w_pre[0] = i_a;

  for (genvar l = 0; l < L; l++) begin : g_lvl
    for (genvar i = 0; i < SEG; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_and
        assign w_pre[l+1][i] =
          w_pre[l][i] & w_pre[l][i-(1<<l)];
      end else begin : g_pass
        assign w_pre[l+1][i] = w_pre[l][i];
      end
    end
  end

  for (genvar i = 0; i < SEG; i++) begin : g_c
    if (i == 0) begin : g_lsb
      assign w_c[i] = i_cin;
    end else begin : g_up
      assign w_c[i] = i_cin & w_pre[L][i-1];
    end
  end

  assign o_sum = i_a ^ w_c;
  assign o_co  = i_cin & w_pre[L][SEG-1];

endmodule

// File: rtl/twos_comp_pipe.sv
// Pipelined two's-complement unit: conditional invert, then an
// increment whose carry ripples one segment per stage.
module twos_comp_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero
);

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad
    $error("twos_comp_pipe: WIDTH must split into STAGES");
  end

  localparam int SEG = WIDTH / STAGES;
  localparam logic [WIDTH-1:0] MNEG =
    WIDTH'(most_neg(WIDTH));

  logic             w_adv;
  logic             w_inv;
  logic             w_cin;
  logic             w_ovf0;
  logic [WIDTH-1:0] w_x;

  // Inputs of each stage: index k feeds stage k
  logic [STAGES-1:0][WIDTH-1:0] w_sd;
  logic [STAGES-1:0]            w_sv;
  logic [STAGES-1:0]            w_sc;
  logic [STAGES-1:0]            w_so;

  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  always_comb begin
    w_inv = 1'b0;
    w_cin = 1'b0;
    unique case (in_mode)
      MODE_PASS: begin
        w_inv = 1'b0;
        w_cin = 1'b0;
      end
      MODE_NEG: begin
        w_inv = 1'b1;
        w_cin = 1'b1;
      end
      MODE_ABS: begin
        w_inv = in_data[WIDTH-1];
        w_cin = in_data[WIDTH-1];
      end
      MODE_ONES: begin
        w_inv = 1'b1;
        w_cin = 1'b0;
      end
    endcase
  end

  assign w_x    = w_inv ? ~in_data : in_data;
  assign w_ovf0 = (in_mode == MODE_NEG ||
                   in_mode == MODE_ABS) &&
                  (in_data == MNEG);

  assign w_sd[0] = w_x;
  assign w_sv[0] = in_valid;
  assign w_sc[0] = w_cin;
  assign w_so[0] = w_ovf0;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic [SEG-1:0]   w_sum;
    logic             w_co;
    logic [WIDTH-1:0] w_nd;
    logic [WIDTH-1:0] r_data;
    logic             r_vld;
    logic             r_ovf;

    seg_inc #(.SEG(SEG)) u_inc (
      .i_a   (w_sd[k][k*SEG +: SEG]),
      .i_cin (w_sc[k]),
      .o_sum (w_sum),
      .o_co  (w_co)
    );

    always_comb begin
      w_nd = w_sd[k];
      w_nd[k*SEG +: SEG] = w_sum;
    end

    // Bubbles carry zeros so no stale value reaches out_data
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_vld  <= 1'b0;
        r_data <= '0;
        r_ovf  <= 1'b0;
      end else if (w_adv) begin
        r_vld  <= w_sv[k];
        r_data <= w_sv[k] ? w_nd : '0;
        r_ovf  <= w_sv[k] & w_so[k];
      end
    end

    if (k < STAGES - 1) begin : g_mid
      logic r_cy;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cy <= 1'b0;
        end else if (w_adv) begin
          r_cy <= w_sv[k] & w_co;
        end
      end

      assign w_sd[k+1] = r_data;
      assign w_sv[k+1] = r_vld;
      assign w_sc[k+1] = r_cy;
      assign w_so[k+1] = r_ovf;
    end else begin : g_last
      logic r_zero;
      logic w_unused_co;

      // Carry out of the top segment is discarded
      assign w_unused_co = w_co;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_zero <= w_sv[k] & ~|w_nd;
        end
      end

      assign out_valid = r_vld;
      assign out_data  = r_data;
      assign out_ovf   = r_ovf;
      assign out_zero  = r_zero;
    end
  end

endmodule

// File: tb/tb_twos_comp_pipe.sv
// Scoreboard bench: 16/4 and 8/1 instances checked against
// an arithmetic reference model.
module tb_twos_comp_pipe;
  import lu_pkg::*;

  typedef struct {
    logic [15:0] d;
    logic        o;
    logic        z;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_iv, a_ir, a_ov, a_or, a_oo, a_oz;
  logic [15:0] a_id, a_od;
  logic [1:0]  a_im;
  logic        b_iv, b_ir, b_ov, b_or, b_oo, b_oz;
  logic [7:0]  b_id, b_od;
  logic [1:0]  b_im;

  twos_comp_pipe #(.WIDTH(16), .STAGES(4)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_data(a_id), .in_mode(a_im),
    .out_valid(a_ov), .out_ready(a_or),
    .out_data(a_od), .out_ovf(a_oo), .out_zero(a_oz)
  );

  twos_comp_pipe #(.WIDTH(8), .STAGES(1)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_data(b_id), .in_mode(b_im),
    .out_valid(b_ov), .out_ready(b_or),
    .out_data(b_od), .out_ovf(b_oo), .out_zero(b_oz)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   pa = 0;
  int   pb = 0;
  int   stall_seen = 0;
  bit   rnd_a = 0;
  bit   rnd_b = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t model(
    input logic [15:0] d, input logic [1:0] m,
    input int w, input int acc, input bit lat);
    exp_t   e;
    longint lim, sv, r;
    lim = longint'(1) << w;
    sv  = longint'(d) & (lim - 1);
    if (sv >= lim / 2) sv = sv - lim;
    case (m)
      MODE_PASS: r = sv;
      MODE_NEG:  r = -sv;
      MODE_ABS:  r = (sv < 0) ? -sv : sv;
      default:   r = -sv - 1;
    endcase
    e.d   = 16'(r & (lim - 1));
    e.z   = (e.d == 16'd0);
    e.o   = (m == MODE_NEG || m == MODE_ABS) &&
            (sv == -(lim / 2));
    e.acc = acc;
    e.lat = lat;
    return e;
  endfunction

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  logic [15:0] a_hold;
  bit          a_held = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("a_in_ready", 16'(a_ir), 16'(!a_ov || a_or));
      if (a_held && a_ov) chk("a_stall_stable", a_od, a_hold);
      a_held = a_ov && !a_or;
      a_hold = a_od;
      if (a_held) stall_seen++;
      if (a_ov && a_or) begin
        pa++;
        if (qa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL a_unexpected actual=%h required=none",
                   a_od);
        end else begin
          e = qa.pop_front();
          chk("a_data", a_od, e.d);
          chk("a_ovf", 16'(a_oo), 16'(e.o));
          chk("a_zero", 16'(a_oz), 16'(e.z));
          if (e.lat) chk("a_latency", 16'(cyc - e.acc), 16'd3);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_ov && b_or) begin
      pb++;
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected actual=%h required=none",
                 b_od);
      end else begin
        e = qb.pop_front();
        chk("b_data", 16'(b_od), e.d);
        chk("b_ovf", 16'(b_oo), 16'(e.o));
        chk("b_zero", 16'(b_oz), 16'(e.z));
        if (e.lat) chk("b_latency", 16'(cyc - e.acc), 16'd0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_a) a_or = ($urandom_range(0, 3) != 0);
    if (rnd_b) b_or = ($urandom_range(0, 2) != 0);
  end

  task automatic send_a(input logic [15:0] d,
                        input logic [1:0] m, input bit lat);
    int n = 0;
    a_iv = 1'b1;
    a_id = d;
    a_im = m;
    forever begin
      @(negedge clk);
      if (a_ir && !rst) break;
      n++;
      if (n > 500) begin
        $display("FAIL a_accept_timeout actual=%0d required=<500",
                 n);
        $fatal(1);
      end
    end
    qa.push_back(model(d, m, 16, cyc + 1, lat));
    @(posedge clk);
    #1 a_iv = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d,
                        input logic [1:0] m, input bit lat);
    int n = 0;
    b_iv = 1'b1;
    b_id = d;
    b_im = m;
    forever begin
      @(negedge clk);
      if (b_ir && !rst) break;
      n++;
      if (n > 500) begin
        $display("FAIL b_accept_timeout actual=%0d required=<500",
                 n);
        $fatal(1);
      end
    end
    qb.push_back(model(16'(d), m, 8, cyc + 1, lat));
    @(posedge clk);
    #1 b_iv = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      if (qa.size() == 0 && !a_ov &&
          qb.size() == 0 && !b_ov) break;
      n++;
      if (n > 300) begin
        tests++;
        fails++;
        $display("FAIL drain_timeout actual=%0d required=0",
                 qa.size() + qb.size());
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h0000;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int p0;
    rst  = 1'b1;
    a_iv = 1'b0; a_id = '0; a_im = '0; a_or = 1'b1;
    b_iv = 1'b0; b_id = '0; b_im = '0; b_or = 1'b1;
    @(negedge clk);
    chk("a_rst_valid", 16'(a_ov), 16'd0);
    chk("a_rst_data", a_od, 16'd0);
    chk("a_rst_ovf", 16'(a_oo), 16'd0);
    chk("a_rst_zero", 16'(a_oz), 16'd0);
    chk("b_rst_valid", 16'(b_ov), 16'd0);
    chk("b_rst_zero", 16'(b_oz), 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    send_a(16'h0005, MODE_NEG, 1);  drain();
    send_a(16'h8000, MODE_NEG, 1);  drain();
    send_a(16'h8000, MODE_ABS, 1);  drain();
    send_a(16'hFFF0, MODE_ABS, 1);  drain();
    send_a(16'h0010, MODE_ABS, 1);  drain();
    send_a(16'h0000, MODE_NEG, 1);  drain();
    send_a(16'h1234, MODE_PASS, 1); drain();
    send_a(16'h1234, MODE_ONES, 1); drain();

    // 8 back-to-back with a 5-cycle consumer stall mid-stream
    p0 = pa;
    stall_seen = 0;
    fork
      for (int i = 0; i < 8; i++)
        send_a(rnd16(), 2'($urandom_range(0, 3)), 0);
      begin
        repeat (5) @(posedge clk);
        #1 a_or = 1'b0;
        repeat (5) @(posedge clk);
        #1 a_or = 1'b1;
      end
    join
    drain();
    chk("a_stream_count", 16'(pa - p0), 16'd8);
    chk("a_stall_seen", 16'(stall_seen >= 5), 16'd1);

    // Flush in-flight operands with a 1-cycle reset
    for (int i = 0; i < 4; i++)
      send_a(rnd16(), MODE_NEG, 0);
    rst = 1'b1;
    #1;
    chk("a_flush_valid", 16'(a_ov), 16'd0);
    qa.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    p0 = pa;
    send_a(16'h7FFF, MODE_NEG, 1);
    drain();
    chk("a_flush_count", 16'(pa - p0), 16'd1);

    rnd_a = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end else begin
        send_a(rnd16(), 2'($urandom_range(0, 3)), 0);
      end
    end
    rnd_a = 0;
    a_or  = 1'b1;
    drain();

    send_b(8'h5A, MODE_ONES, 1); drain();
    send_b(8'h00, MODE_PASS, 1); drain();
    send_b(8'h80, MODE_ABS, 1);  drain();
    send_b(8'hF0, MODE_NEG, 1);  drain();
    rnd_b = 1;
    for (int i = 0; i < 80; i++)
      send_b(8'($urandom), 2'($urandom_range(0, 3)), 0);
    rnd_b = 0;
    b_or  = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/twos_comp_pipe.md
# twos_comp_pipe

Parametrised, pipelined two's-complement unit that replaces the fixed 16-bit combinational negator in the LU datapath. A WIDTH-bit operand is conditionally inverted, then incremented by a carry chain split into STAGES equal segments, one segment per pipeline stage. The block supports pass, negate, absolute-value and ones'-complement modes. Input and output use valid/ready handshakes with full backpressure and a throughput of one operand per cycle.

## Interface
- WIDTH, 16: operand width; WIDTH % STAGES == 0 is required, and elaboration fails otherwise.
- STAGES, 4: pipeline depth and number of carry segments; must be ≥ 1. SEG = WIDTH/STAGES.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  an operand is presented.
- in_ready  out  1  the block accepts the operand this cycle.
- in_data  in  WIDTH  operand, two's-complement signed.
- in_mode  in  2  00 pass, 01 negate, 10 absolute, 11 ones'-complement.
- out_valid  out  1  a result is presented.
- out_ready  in  1  the consumer accepts the result.
- out_data  out  WIDTH  result.
- out_ovf  out  1  the result is not representable: negate or abs of the most-negative value (100…0).
- out_zero  out  1  out_data == 0.

## Operation
- Effective invert flag inv: mode 01 → 1; mode 10 → in_data[WIDTH-1]; mode 11 → 1; mode 00 → 0.
- Effective carry-in cin: mode 01 → 1; mode 10 → in_data[WIDTH-1]; modes 00 and 11 → 0.
- Stage 0:
  - x = inv ? ~in_data : in_data.
  - Segment 0 = x[SEG-1:0] + cin, producing sum and carry c0.
  - Segments 1..STAGES-1 pass through unmodified.
- Stage k (1..STAGES-1): segment k = seg_k + c(k-1), producing carry ck. Lower segments are already final; upper segments are still untouched.
- The final carry out of the top segment is discarded.
- ovf is computed at stage 0 and carried with the data:
  - set when in_mode ∈ {01,10} and in_data == {1'b1, {WIDTH-1{1'b0}}};
  - otherwise 0 (mode 11 never overflows).
- out_zero is computed from the final-stage data register. It is registered, not combinational on out_data.
- Each stage holds a valid bit, a data register, a carry bit and an ovf bit.

## Timing
- Reset: every stage valid bit = 0, every data/carry/ovf register = 0. Therefore out_valid = 0, out_data = 0, out_ovf = 0, out_zero = 0 while rst is high and until the first result arrives.
- Reset asserted mid-operation discards all in-flight operands. No partial result is ever presented.
- Advance signal adv = ~out_valid | out_ready. in_ready = adv, combinationally.
- When adv = 1, all stages shift by one: stage 0 loads {in_valid, computed values}.
- When adv = 0, every stage holds, and in_data is not sampled even if in_valid = 1.
- Latency: an operand accepted on edge N appears with out_valid = 1 after edge N+STAGES-1.
  - STAGES = 1 gives a result on the cycle after acceptance.
- out_data, out_ovf and out_zero stay stable while out_valid = 1 and out_ready = 0.
- Bubbles (in_valid = 0 while adv = 1) propagate as invalid stages. Results keep their order and are never duplicated or dropped.
- A simultaneous output accept and input accept in the same cycle is legal and sustains one result per cycle.

## Structure
- Shared package lu_pkg holds:
  - the mode encoding constants MODE_PASS, MODE_NEG, MODE_ABS, MODE_ONES;
  - a function giving the most-negative value for a width.
- Sub-module seg_inc (parametrised SEG): SEG-bit value + 1-bit carry-in → SEG-bit sum, carry-out.
  - Implemented as a recursive-doubling (parallel-prefix) incrementer.
  - One instance per stage, generated STAGES times.
- Pipeline registers and handshake live in twos_comp_pipe itself. The expected size is about 150–250 lines.

## Test plan
- WIDTH=16, STAGES=4; mode 01, in_data=0x0005, out_ready=1 → after 3 edges out_data=0xFFFB, ovf=0, zero=0.
- Mode 01, in_data=0x8000 → out_data=0x8000, out_ovf=1. Mode 10 on the same value → 0x8000, ovf=1.
- Mode 10 on 0xFFF0 → 0x0010. Mode 10 on 0x0010 → 0x0010. Mode 01 on 0x0000 → 0x0000, zero=1, ovf=0. This also checks that the carry ripples across all 4 segments.
- Stream 8 back-to-back operands; hold out_ready=0 for 5 cycles mid-stream. The bench checks:
  - in_ready drops in the same cycle out_valid & ~out_ready holds;
  - out_data is stable during the stall;
  - all 8 results arrive in order with none lost.
- Assert rst for 1 cycle with 3 operands in flight → out_valid=0 immediately, and the following operand is the first result seen.
- WIDTH=8, STAGES=1; mode 11 on 0x5A → 0xA5 one cycle later; mode 00 on 0x00 → 0x00, zero=1.
